// File: rtl/potential_decay_array.sv
// rtl/potential_decay_array.sv - clocked LIF membrane-potential decay array with valid/ready output stream
// Optional feature: define DECAY_THREE_QUARTER_EN to enable the x0.75 decay code (4'b0011).
module potential_decay_array #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic              wr_rate_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_potential,
  input  logic [3:0]        wr_rate,
  output logic              wr_ready,
  input  logic              decay_start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [31:0]       pot  [NUM_NEURONS];
  logic [3:0]        rate [NUM_NEURONS];
  logic [ADDR_W-1:0] idx;
  logic              load, finish, last, wr_ok;
  logic [31:0]       decayed;

  // Exponent-only decay with truncation; zero/denormal flush and Inf/NaN pass-through.
  function automatic logic [31:0] decay(input logic [31:0] p, input logic [3:0] r);
    logic       s;
    logic [7:0] e;
    logic [1:0] sub;
    logic [31:0] res;
`ifdef DECAY_THREE_QUARTER_EN
    logic [24:0] sum;
`endif
    s   = p[31];
    e   = p[30:23];
    sub = 2'd0;
    case (r)
      4'b0010: sub = 2'd1;
      4'b0100: sub = 2'd2;
      4'b1000: sub = 2'd3;
      default: sub = 2'd0;
    endcase
    if (e == 8'd0)
      res = {s, 31'b0};
    else if (e == 8'hFF)
      res = p;
`ifdef DECAY_THREE_QUARTER_EN
    else if (r == 4'b0011) begin
      sum = {1'b0, 1'b1, p[22:0]} + {2'b0, 1'b1, p[22:1]};
      if (sum[24])
        res = {s, e, sum[23:1]};
      else if (e == 8'd1)
        res = {s, 31'b0};
      else
        res = {s, e - 8'd1, sum[22:0]};
    end
`endif
    else if (e <= {6'b0, sub})
      res = {s, 31'b0};
    else
      res = {s, e - {6'b0, sub}, p[22:0]};
    return res;
  endfunction

  assign busy     = (state != IDLE);
  assign wr_ready = !busy;
  assign wr_ok    = (state == IDLE) && (int'(wr_addr) < NUM_NEURONS);
  assign last     = (idx == ADDR_W'(NUM_NEURONS - 1));
  assign decayed  = decay(pot[idx], rate[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:  if (decay_start) state_nxt = SWEEP;
      SWEEP: if (!out_valid || out_ready) begin
        load = 1'b1;
        if (last) state_nxt = DRAIN;
      end
      DRAIN: if (out_ready) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writes land in IDLE only, so a write coinciding with decay_start is seen by the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot[i]  <= 32'h0000_0000;
        rate[i] <= 4'b0001;
      end
    end else begin
      if (wr_ok && wr_valid)      pot[wr_addr]  <= wr_potential;
      if (wr_ok && wr_rate_valid) rate[wr_addr] <= wr_rate;
      if (load)                   pot[idx]      <= decayed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_potential <= 32'h0;
      done          <= 1'b0;
    end else begin
      done <= finish;
      if (state == IDLE && decay_start) idx <= '0;
      if (load) begin
        out_valid     <= 1'b1;
        out_addr      <= idx;
        out_potential <= decayed;
        idx           <= idx + 1'b1;
      end
      if (finish) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_potential_decay_array.sv
// tb/tb_potential_decay_array.sv - directed self-checking bench for potential_decay_array
module tb_potential_decay_array;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_rate_valid;
  logic [3:0]  wr_addr;
  logic [31:0] wr_potential;
  logic [3:0]  wr_rate;
  logic        wr_ready;
  logic        decay_start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_addr;
  logic [31:0] out_potential;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_pot [16];

  potential_decay_array #(.NUM_NEURONS(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_rate_valid(wr_rate_valid), .wr_addr(wr_addr),
    .wr_potential(wr_potential), .wr_rate(wr_rate), .wr_ready(wr_ready),
    .decay_start(decay_start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_potential(out_potential), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".wr_ready"},      32'(wr_ready),      32'd1);
    chk({tag, ".busy"},          32'(busy),          32'd0);
    chk({tag, ".out_valid"},     32'(out_valid),     32'd0);
    chk({tag, ".out_addr"},      32'(out_addr),      32'd0);
    chk({tag, ".out_potential"}, out_potential,      32'd0);
    chk({tag, ".done"},          32'(done),          32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] p, input logic [3:0] r);
    @(negedge clk);
    wr_valid = 1'b1; wr_rate_valid = 1'b1; wr_addr = a; wr_potential = p; wr_rate = r;
    @(negedge clk);
    wr_valid = 1'b0; wr_rate_valid = 1'b0;
  endtask

  // One timestep sweep; optional same-cycle write at start, stall, in-sweep poke, or reset.
  task automatic sweep(input string tag, input bit w_en, input logic [3:0] w_addr,
                       input logic [31:0] w_pot, input int stall_at, input int stall_len,
                       input bit poke, input int rst_at, input int exp_done);
    int edge_n, expect_idx, stall_rem, done_cnt, done_edge;
    bit poked;
    expect_idx = 0; stall_rem = stall_len; done_cnt = 0; done_edge = -1; poked = 0;
    @(negedge clk);
    decay_start = 1'b1; out_ready = 1'b1;
    if (w_en) begin
      wr_valid = 1'b1; wr_rate_valid = 1'b1; wr_addr = w_addr; wr_potential = w_pot; wr_rate = 4'b0010;
    end
    @(posedge clk);
    edge_n = 0;
    while (edge_n < 100) begin
      @(negedge clk);
      decay_start = 1'b0; wr_valid = 1'b0; wr_rate_valid = 1'b0;
      if (edge_n == 0) begin
        chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, ".wr_ready_after_start"}, 32'(wr_ready), 32'd0);
      end
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = edge_n;
      end
      if (done_edge >= 0 && edge_n >= done_edge + 3) break;
      if (rst_at >= 0 && out_valid && expect_idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs({tag, ".midsweep_rst"});
        @(negedge clk);
        chk({tag, ".done_in_rst"}, 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, ".done_after_rst"}, 32'(done), 32'd0);
        chk({tag, ".busy_after_rst"}, 32'(busy), 32'd0);
        return;
      end
      if (out_valid) begin
        chk($sformatf("%s.addr%0d", tag, expect_idx), 32'(out_addr), 32'(expect_idx));
        chk($sformatf("%s.pot%0d", tag, expect_idx), out_potential, exp_pot[expect_idx]);
        if (poke && !poked && expect_idx == 5) begin
          chk({tag, ".wr_ready_in_sweep"}, 32'(wr_ready), 32'd0);
          wr_valid = 1'b1; wr_rate_valid = 1'b1; wr_addr = 4'd0;
          wr_potential = 32'h3F80_0000; wr_rate = 4'b0001; decay_start = 1'b1;
          poked = 1;
        end
        if (expect_idx == stall_at && stall_rem > 0) begin
          out_ready = 1'b0;
          stall_rem--;
        end else begin
          out_ready = 1'b1;
          expect_idx++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk);
      edge_n++;
    end
    chk({tag, ".done_edge"}, 32'(done_edge), 32'(exp_done));
    chk({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, ".neurons_accepted"}, 32'(expect_idx), 32'd16);
    chk({tag, ".idle_wr_ready"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_rate_valid = 1'b0; wr_addr = '0;
    wr_potential = '0; wr_rate = '0; decay_start = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    // Pass 1: rate and boundary vectors; neuron 15 written in the same cycle as decay_start.
    wr(4'd0, 32'h41DE_B852, 4'b0010);
    wr(4'd1, 32'h41DE_B852, 4'b1000);
    wr(4'd2, 32'h41DE_B852, 4'b0011);
    wr(4'd3, 32'h0080_0000, 4'b0010);
    wr(4'd4, 32'h8080_0000, 4'b0010);
    wr(4'd5, 32'h7F80_0000, 4'b0010);
    wr(4'd6, 32'h0000_0000, 4'b0010);
    for (int i = 7; i < 15; i++) wr(4'(i), 32'h4000_0000, 4'b0010);
    exp_pot[0] = 32'h415E_B852;
    exp_pot[1] = 32'h405E_B852;
`ifdef DECAY_THREE_QUARTER_EN
    exp_pot[2] = 32'h41A7_0A3D;
`else
    exp_pot[2] = 32'h41DE_B852;
`endif
    exp_pot[3] = 32'h0000_0000;
    exp_pot[4] = 32'h8000_0000;
    exp_pot[5] = 32'h7F80_0000;
    exp_pot[6] = 32'h0000_0000;
    for (int i = 7; i < 16; i++) exp_pot[i] = 32'h3F80_0000;
    sweep("pass1", 1'b1, 4'd15, 32'h4000_0000, -1, 0, 1'b0, -1, 17);

    // Pass 2: halved again, stall at neuron 3, write + start attempted mid-sweep.
    exp_pot[0] = 32'h40DE_B852;
    exp_pot[1] = 32'h3EDE_B852;
`ifdef DECAY_THREE_QUARTER_EN
    exp_pot[2] = 32'h417A_8F5B;
`else
    exp_pot[2] = 32'h41DE_B852;
`endif
    exp_pot[3] = 32'h0000_0000;
    exp_pot[4] = 32'h8000_0000;
    exp_pot[5] = 32'h7F80_0000;
    exp_pot[6] = 32'h0000_0000;
    for (int i = 7; i < 16; i++) exp_pot[i] = 32'h3F00_0000;
    sweep("pass2", 1'b0, 4'd0, 32'h0, 3, 5, 1'b1, -1, 22);

    // Pass 3: blocked write must not have landed; reset at neuron 7.
    exp_pot[0] = 32'h405E_B852;
    exp_pot[1] = 32'h3D5E_B852;
`ifdef DECAY_THREE_QUARTER_EN
    exp_pot[2] = 32'h413B_EB84;
`else
    exp_pot[2] = 32'h41DE_B852;
`endif
    for (int i = 3; i < 16; i++) exp_pot[i] = exp_pot[i];
    for (int i = 7; i < 16; i++) exp_pot[i] = 32'h3E80_0000;
    sweep("pass3", 1'b0, 4'd0, 32'h0, -1, 0, 1'b0, 7, 17);

    // Pass 4: arrays were reset, every neuron decays from zero.
    for (int i = 0; i < 16; i++) exp_pot[i] = 32'h0000_0000;
    sweep("pass4", 1'b0, 4'd0, 32'h0, -1, 0, 1'b0, -1, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/potential_decay_array.md
# potential_decay_array

Multi-neuron leaky-integrate-and-fire decay engine that replaces the single-neuron, event-triggered decay cell with a clocked, parametrised array. It holds the membrane potential (IEEE-754 single) and a 4-bit decay-rate code for `NUM_NEURONS` neurons. On each timestep it sweeps every neuron, applies its decay, writes the result back, and streams each decayed potential to the spike/threshold stage over a valid/ready interface. It sits between the potential adder (writer) and the threshold comparator (consumer) in the neuron core.

## Interface
- `NUM_NEURONS`, 16: neurons held; ≥2.
- `ADDR_W`, 4: neuron address width; must be ≥ clog2(`NUM_NEURONS`).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_valid` input 1: write potential `wr_potential` to `wr_addr`.
- `wr_rate_valid` input 1: write rate `wr_rate` to `wr_addr`; may coincide with `wr_valid`.
- `wr_addr` input `ADDR_W`: target neuron.
- `wr_potential` input 32: IEEE-754 single potential.
- `wr_rate` input 4: decay code.
- `wr_ready` output 1: high only in IDLE; writes are ignored when low.
- `decay_start` input 1: one-cycle pulse that begins a timestep sweep.
- `busy` output 1: sweep in progress.
- `out_valid` output 1: `out_addr`/`out_potential` hold a decayed neuron.
- `out_ready` input 1: consumer accepts.
- `out_addr` output `ADDR_W`: neuron index of the output.
- `out_potential` output 32: decayed potential.
- `done` output 1: one-cycle pulse on the edge that the last neuron's output is accepted.

## Operation
- Storage: register arrays `pot[NUM_NEURONS]` and `rate[NUM_NEURONS]`.
  - Reset values: pot = 0x00000000, rate = 4'b0001.
- Writes are accepted only in IDLE. Writes to `wr_addr ≥ NUM_NEURONS` are dropped.
- States:
  - IDLE: `decay_start` → SWEEP with idx=0. `decay_start` is ignored outside IDLE.
  - SWEEP: while the output register is free (`!out_valid || out_ready`):
    - compute decay of `pot[idx]` combinationally;
    - write the result to `pot[idx]`;
    - load `out_*` and set `out_valid`;
    - increment idx.
    - After loading idx = `NUM_NEURONS`-1 → DRAIN.
  - DRAIN: when `out_ready` is sampled high, clear `out_valid`, pulse `done`, and return to IDLE.
- Decay on fields s, e (8 bit), m (23 bit):
  - 0001: ×1.
  - 0010: e−1.
  - 0100: e−2.
  - 1000: e−3.
  - 0011: ×0.75. Form S = {1,m} + ({1,m}>>1) (25 bit, truncating). If S[24]: mantissa = S[23:1], e unchanged. Else: mantissa = S[22:0], e−1.
  - Any other code: ×1.
- Special inputs:
  - e = 0 (zero/denormal) → output signed zero {s, 31'b0}.
  - e = 255 (Inf/NaN) → passed through unchanged.
  - Exponent result ≤ 0 → flush to signed zero. Sign is always preserved.
- Rounding: truncation only.

## Timing
- Reset values: `wr_ready`=1, `busy`=0, `out_valid`=0, `out_addr`=0, `out_potential`=0, `done`=0.
- `busy` = state ≠ IDLE; `wr_ready` = !busy.
- With `out_ready` held high:
  - `decay_start` sampled at edge E0.
  - Neuron i is presented after edge E(i+1).
  - Sweep complete: `done` is high after E(`NUM_NEURONS`+1). IDLE and `wr_ready` are reached on that same edge.
- Handshake: while `out_valid && !out_ready`, `out_addr`/`out_potential` are held stable and idx does not advance.
- A `decay_start` and a write in the same IDLE cycle: both take effect. The write lands first, and the sweep sees the written value.
- `rst_n` low mid-sweep: immediate return to IDLE and all arrays reset. No `done` is produced.

## Configuration
- `DECAY_THREE_QUARTER_EN`:
  - Defined: code 0011 performs ×0.75 as above.
  - Undefined: the adder path is not compiled and 0011 decays ×1 like other unlisted codes.

## Test plan
- Write neuron 0 = 0x41DEB852, rate 0010; pulse start with `out_ready`=1 → neuron 0 outputs 0x415EB852. With rate 1000 → 0x405EB852. `done` rises after `NUM_NEURONS`+1 edges.
- `DECAY_THREE_QUARTER_EN` defined, 0x41DEB852 rate 0011 → 0x41A70A3D. Undefined → 0x41DEB852.
- Boundaries, rate 0010:
  - 0x00800000 → 0x00000000;
  - 0x80800000 → 0x80000000;
  - 0x7F800000 → 0x7F800000;
  - 0x00000000 → 0x00000000.
- `out_ready` low for 5 cycles at neuron 3 → `out_addr`=3 and its data are held stable. No neuron is skipped or duplicated. A second sweep shows each potential halved again.
- `wr_valid` during SWEEP → `wr_ready`=0 and the value is not stored. `decay_start` during SWEEP → ignored, and only one `done` pulse occurs.
- `rst_n` pulsed low at neuron 7 → all outputs return to reset values. A subsequent sweep outputs 0x00000000 for every neuron.
